// File: rtl/prog_shift_reg_if.sv
// Bus bundle for prog_shift_reg: request/operand signals from the
// requester plus register contents and status back from the engine.
interface prog_shift_reg_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned AW = $clog2(N) + 1
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic          sin;
  logic [N-1:0]  D;
  logic [N-1:0]  Q;
  logic          cout;
  logic          busy;
  logic          done;

  // Requester side.
  modport master (
    output start, op, amt, sin, D,
    input  Q, cout, busy, done
  );

  // Shift engine side.
  modport slave (
    input  start, op, amt, sin, D,
    output Q, cout, busy, done
  );
endinterface

// File: rtl/prog_shift_reg.sv
// Multi-mode shift engine: parallel load, or a programmed multi-position
// shift/rotate carried out STEP positions per clock under a start/busy/done
// handshake. cout reports the last bit shifted or rotated out.
module prog_shift_reg #(
  parameter int unsigned N    = 8,
  parameter int unsigned STEP = 1
) (
  input logic             clk,
  input logic             n_reset,
  prog_shift_reg_if.slave bus
);

  localparam int unsigned AW = $clog2(N) + 1;

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpShl  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpAsr  = 3'b011;
  localparam logic [2:0] OpRol  = 3'b100;
  localparam logic [2:0] OpRor  = 3'b101;

  localparam logic [AW-1:0] NW    = AW'(N);
  localparam logic [AW-1:0] StepW = AW'(STEP);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          cout_q, cout_d;
  logic [2:0]    op_q, op_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  logic [AW-1:0] amt_clamp;
  logic [AW-1:0] step_k;
  logic [AW-1:0] cnt_next;
  logic [N-1:0]  shift_q;
  logic          shift_out;

  // Distance clamp at capture and positions moved this clock.
  always_comb begin
    amt_clamp = (bus.amt > NW) ? NW : bus.amt;
    step_k    = (cnt_q < StepW) ? cnt_q : StepW;
    cnt_next  = cnt_q - step_k;
  end

  // One step of up to STEP positions, built as a chain of single-position
  // moves; the last bit leaving the chain is the required cout.
  always_comb begin
    shift_q   = q_q;
    shift_out = cout_q;
    for (int unsigned i = 0; i < STEP; i++) begin
      if (AW'(i) < step_k) begin
        case (op_q)
          OpShl: begin
            shift_out = shift_q[N-1];
            shift_q   = {shift_q[N-2:0], bus.sin};
          end
          OpShr: begin
            shift_out = shift_q[0];
            shift_q   = {bus.sin, shift_q[N-1:1]};
          end
          OpAsr: begin
            // Sign bit never changes under ASR, so re-copying it each
            // single move matches sampling it once before the step.
            shift_out = shift_q[0];
            shift_q   = {shift_q[N-1], shift_q[N-1:1]};
          end
          OpRol: begin
            shift_out = shift_q[N-1];
            shift_q   = {shift_q[N-2:0], shift_q[N-1]};
          end
          OpRor: begin
            shift_out = shift_q[0];
            shift_q   = {shift_q[0], shift_q[N-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  // Next-state logic for the IDLE/RUN controller and datapath.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cout_d  = cout_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.op == OpLoad) begin
            q_d    = bus.D;
            done_d = 1'b1;
          end else if (bus.op > OpRor || amt_clamp == '0) begin
            // Reserved op or zero distance: acknowledge without change.
            done_d = 1'b1;
          end else begin
            op_d    = bus.op;
            cnt_d   = amt_clamp;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        q_d    = shift_q;
        cout_d = shift_out;
        cnt_d  = cnt_next;
        if (cnt_next == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      cout_q  <= 1'b0;
      op_q    <= OpLoad;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.Q    = q_q;
  assign bus.cout = cout_q;
  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;

endmodule

// File: tb/tb_prog_shift_reg.sv
// Bench for prog_shift_reg: one N=8/STEP=1 instance and one N=8/STEP=3
// instance. Directed stimulus pushes expected completion values into a
// per-instance queue; a monitor pops and compares on every done pulse.
module tb_prog_shift_reg;

  localparam logic [2:0] OpLoad = 3'b000;
  localparam logic [2:0] OpShl  = 3'b001;
  localparam logic [2:0] OpShr  = 3'b010;
  localparam logic [2:0] OpAsr  = 3'b011;
  localparam logic [2:0] OpRol  = 3'b100;
  localparam logic [2:0] OpRor  = 3'b101;
  localparam logic [2:0] OpRsv  = 3'b110;

  typedef struct packed {
    logic [7:0] q;
    logic       c;
  } exp_t;

  logic clk;
  logic n_reset;

  int checks   = 0;
  int failures = 0;
  int dones1   = 0;
  int dones2   = 0;
  int want1    = 0;
  int want2    = 0;

  exp_t exp1[$];
  exp_t exp2[$];

  prog_shift_reg_if #(.N(8)) bus1 ();
  prog_shift_reg_if #(.N(8)) bus2 ();

  prog_shift_reg #(.N(8), .STEP(1)) u_dut1 (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus1)
  );

  prog_shift_reg #(.N(8), .STEP(3)) u_dut2 (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [7:0] get_q(input int sel);
    return (sel == 0) ? bus1.Q : bus2.Q;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus1.busy : bus2.busy;
  endfunction

  function automatic logic get_done(input int sel);
    return (sel == 0) ? bus1.done : bus2.done;
  endfunction

  task automatic set_in(input int sel, input logic st, input logic [2:0] op,
                        input logic [3:0] amt, input logic sn, input logic [7:0] d);
    if (sel == 0) begin
      bus1.start = st; bus1.op = op; bus1.amt = amt; bus1.sin = sn; bus1.D = d;
    end else begin
      bus2.start = st; bus2.op = op; bus2.amt = amt; bus2.sin = sn; bus2.D = d;
    end
  endtask

  task automatic expect_done(input int sel, input logic [7:0] q, input logic c);
    exp_t e;
    e.q = q;
    e.c = c;
    if (sel == 0) begin exp1.push_back(e); want1++; end
    else begin exp2.push_back(e); want2++; end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one accepting edge; returns 1 ns after that edge.
  task automatic issue(input int sel, input logic [2:0] op, input logic [3:0] amt,
                       input logic sn, input logic [7:0] d);
    set_in(sel, 1'b1, op, amt, sn, d);
    @(posedge clk);
    #1;
    if (sel == 0) bus1.start = 1'b0;
    else bus2.start = 1'b0;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (n_reset) begin
      if (bus1.done) begin
        dones1++;
        if (exp1.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut1 unexpected done: Q=%h cout=%b", bus1.Q, bus1.cout);
        end else begin
          exp_t e1;
          e1 = exp1.pop_front();
          chk8("dut1 done Q", bus1.Q, e1.q);
          chk1("dut1 done cout", bus1.cout, e1.c);
        end
      end
      if (bus2.done) begin
        dones2++;
        if (exp2.size() == 0) begin
          checks++; failures++;
          $display("FAIL dut2 unexpected done: Q=%h cout=%b", bus2.Q, bus2.cout);
        end else begin
          exp_t e2;
          e2 = exp2.pop_front();
          chk8("dut2 done Q", bus2.Q, e2.q);
          chk1("dut2 done cout", bus2.cout, e2.c);
        end
      end
    end
  end

  initial begin
    logic [7:0] shl_seq [4];
    logic [7:0] ror_seq [3];
    shl_seq[0] = 8'hA5; shl_seq[1] = 8'h4B; shl_seq[2] = 8'h97; shl_seq[3] = 8'h2F;
    ror_seq[0] = 8'h01; ror_seq[1] = 8'h20; ror_seq[2] = 8'h08;

    n_reset = 1'b0;
    set_in(0, 1'b0, OpLoad, 4'd0, 1'b0, 8'h00);
    set_in(1, 1'b0, OpLoad, 4'd0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk8("reset Q", get_q(s), 8'h00);
      chk1("reset busy", get_busy(s), 1'b0);
      chk1("reset done", get_done(s), 1'b0);
    end
    chk1("reset cout", bus1.cout, 1'b0);
    n_reset = 1'b1;

    // LOAD A5: done one cycle after acceptance, no busy.
    sync();
    expect_done(0, 8'hA5, 1'b0);
    issue(0, OpLoad, 4'd0, 1'b0, 8'hA5);
    @(negedge clk);
    chk1("load busy", bus1.busy, 1'b0);
    chk1("load done", bus1.done, 1'b1);

    // SHL 3 with sin=1: A5 -> 4B -> 97 -> 2F, cout=1.
    sync();
    expect_done(0, 8'h2F, 1'b1);
    issue(0, OpShl, 4'd3, 1'b1, 8'h00);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk8("shl step Q", bus1.Q, shl_seq[j]);
      chk1("shl busy", bus1.busy, j < 3);
    end

    // LOAD 85 keeps cout=1; ASR 2 -> E1, cout=0, done two edges later.
    sync();
    expect_done(0, 8'h85, 1'b1);
    issue(0, OpLoad, 4'd0, 1'b0, 8'h85);
    expect_done(0, 8'hE1, 1'b0);
    issue(0, OpAsr, 4'd2, 1'b0, 8'h00);
    @(negedge clk);
    chk1("asr done early", bus1.done, 1'b0);
    @(negedge clk);
    chk1("asr busy last", bus1.busy, 1'b1);
    @(negedge clk);
    chk1("asr done", bus1.done, 1'b1);

    // LOAD FF, SHR 12 clamps to 8; a mid-run LOAD request is ignored.
    sync();
    expect_done(0, 8'hFF, 1'b0);
    issue(0, OpLoad, 4'd0, 1'b0, 8'hFF);
    expect_done(0, 8'h00, 1'b1);
    issue(0, OpShr, 4'd12, 1'b0, 8'h00);
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk8("shr step Q", bus1.Q, 8'hFF >> j);
      chk1("shr busy", bus1.busy, j < 8);
      if (j == 3) set_in(0, 1'b1, OpLoad, 4'd0, 1'b0, 8'h3C);
      if (j == 4) bus1.start = 1'b0;
    end

    // Zero distance and reserved op: acknowledge only.
    sync();
    expect_done(0, 8'h00, 1'b1);
    issue(0, OpShl, 4'd0, 1'b1, 8'h00);
    @(negedge clk);
    chk1("noop busy", bus1.busy, 1'b0);
    sync();
    expect_done(0, 8'h00, 1'b1);
    issue(0, OpRsv, 4'd3, 1'b1, 8'hAA);
    @(negedge clk);
    chk1("rsv busy", bus1.busy, 1'b0);

    // Back-to-back: ROR accepted in the very cycle ROL reports done.
    sync();
    expect_done(0, 8'h81, 1'b1);
    issue(0, OpLoad, 4'd0, 1'b0, 8'h81);
    expect_done(0, 8'h03, 1'b1);
    issue(0, OpRol, 4'd1, 1'b0, 8'h00);
    sync();
    chk1("b2b first done", bus1.done, 1'b1);
    expect_done(0, 8'h81, 1'b1);
    issue(0, OpRor, 4'd1, 1'b0, 8'h00);
    chk1("b2b second busy", bus1.busy, 1'b1);
    sync();
    chk1("b2b second done", bus1.done, 1'b1);

    // Reset in the middle of ROL 6; the operation is lost.
    sync();
    issue(0, OpRol, 4'd6, 1'b0, 8'h00);
    @(posedge clk);
    #3;
    chk1("pre-reset busy", bus1.busy, 1'b1);
    n_reset = 1'b0;
    #1;
    chk8("mid reset Q", bus1.Q, 8'h00);
    chk1("mid reset cout", bus1.cout, 1'b0);
    chk1("mid reset busy", bus1.busy, 1'b0);
    chk1("mid reset done", bus1.done, 1'b0);
    @(negedge clk);
    n_reset = 1'b1;
    sync();
    expect_done(0, 8'h5A, 1'b0);
    issue(0, OpLoad, 4'd0, 1'b0, 8'h5A);
    @(negedge clk);
    chk1("post-reset load done", bus1.done, 1'b1);

    // STEP=3 instance: ROR 5 on 01 in steps of 3 then 2.
    sync();
    expect_done(1, 8'h01, 1'b0);
    issue(1, OpLoad, 4'd0, 1'b0, 8'h01);
    expect_done(1, 8'h08, 1'b0);
    issue(1, OpRor, 4'd5, 1'b0, 8'h00);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk8("ror3 step Q", bus2.Q, ror_seq[j]);
      chk1("ror3 busy", bus2.busy, j < 2);
    end

    // SHL 8 with sin=1: 08 -> 47 -> 3F -> FF, last out Q[6]=0.
    sync();
    expect_done(1, 8'hFF, 1'b0);
    issue(1, OpShl, 4'd8, 1'b1, 8'h00);
    repeat (3) sync();

    // ROL 8 returns the original value; ASR 8 floods with the sign bit.
    expect_done(1, 8'h96, 1'b0);
    issue(1, OpLoad, 4'd0, 1'b0, 8'h96);
    expect_done(1, 8'h96, 1'b0);
    issue(1, OpRol, 4'd8, 1'b0, 8'h00);
    repeat (3) sync();
    expect_done(1, 8'hFF, 1'b1);
    issue(1, OpAsr, 4'd8, 1'b0, 8'h00);
    repeat (4) sync();

    chk8("dut1 pending expectations", 8'(exp1.size()), 8'd0);
    chk8("dut2 pending expectations", 8'(exp2.size()), 8'd0);
    chk8("dut1 done count", 8'(dones1), 8'(want1));
    chk8("dut2 done count", 8'(dones2), 8'(want2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_shift_reg.md
# prog_shift_reg

Parametrised multi-mode shift engine: an N-bit register that performs a programmed multi-position shift or rotate, or a parallel load, under a start/busy/done handshake. It moves up to STEP positions per clock and reports the last bit shifted out. It is the sequential successor of the team's single-step universal shift register, for datapaths that need variable-distance, arithmetic or rotate shifts without a barrel shifter.

## Interface
- N, default 8: register width, N ≥ 2.
- STEP, default 1: maximum positions moved per clock, 1 ≤ STEP ≤ N.
- AW, derived, $clog2(N)+1: width of the shift-amount port.
- clk  input  1  clock; all state changes on the rising edge.
- n_reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- op  input  3  operation: 000 LOAD, 001 SHL, 010 SHR, 011 ASR, 100 ROL, 101 ROR, 110/111 reserved.
- amt  input  AW  shift distance; values > N are clamped to N at capture.
- sin  input  1  fill bit for SHL/SHR, sampled at every shift step.
- D  input  N  parallel load data.
- Q  output  N  register contents.
- cout  output  1  last bit shifted or rotated out.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE and RUN. Registered state holds Q, cout, op_r, cnt (AW bits), done.
- In IDLE with start=1 at an edge:
  - LOAD: Q←D, done←1, stay IDLE.
  - Reserved op, or clamped amt=0: Q and cout unchanged, done←1, stay IDLE.
  - Otherwise: op_r←op, cnt←min(amt,N), go to RUN, done←0.
- In RUN, at each edge: k=min(STEP,cnt); shift Q by k positions; cnt←cnt−k. If the new cnt is 0, go to IDLE and set done←1.
- Shift rules:
  - SHL fills the LSBs with sin.
  - SHR fills the MSBs with sin.
  - ASR fills the MSBs with Q[N−1] sampled before the step.
  - ROL and ROR wrap the bits around.
- cout at each step:
  - SHL and ROL: the pre-step Q[N−k].
  - SHR, ASR and ROR: the pre-step Q[k−1].
- cout is unchanged by LOAD and no-op operations.
- start, op, amt and D are ignored while in RUN. The in-flight operation is never aborted except by reset.
- done is low in every cycle it is not explicitly set.
- busy = (state==RUN).
- A shift by N is allowed:
  - SHL/SHR yield all-sin.
  - ASR yields all copies of the sign bit.
  - ROL/ROR return the original value.
  - In all cases cout follows the per-step rule above.

## Timing
- Reset (asynchronous, any time including mid-RUN):
  - Q=0, cout=0, busy=0, done=0.
  - State goes to IDLE and cnt=0.
  - The operation is lost.
- Accepting edge t0: start sampled high in IDLE.
- LOAD and no-op: Q is updated and done=1 after t0. busy never asserts.
- Shift/rotate: busy=1 from t0 through t0+C−1, where C=ceil(min(amt,N)/STEP).
  - Q updates at edges t0+1 … t0+C.
  - done=1 and busy=0 in the cycle after edge t0+C, together with the final Q and cout.
- Back-to-back: a start presented in the cycle where done=1 is accepted, because the FSM is already in IDLE. There is no dead cycle.
- Throughput: one operation per C+1 clocks when continuously requested.

## Test plan
- Reset, then LOAD with D=8'hA5 (N=8, STEP=1): Q=A5 and done=1 one cycle after the accepting edge; busy stays 0; cout=0.
- From Q=A5, SHL with amt=3 and sin=1: busy is high for 3 cycles, Q passes through 4B, 97, 2F; final Q=2F, cout=1, done pulses once.
- From Q=85, ASR with amt=2: final Q=E1, cout=0, done two edges after acceptance.
- STEP=3, Q=01, ROR with amt=5: two steps (3, then 2), intermediate Q=20, final Q=08, cout=0, busy high for 2 cycles.
- From Q=FF, SHR with amt=12 and sin=0: amt clamps to 8, final Q=00, cout=1, 8 busy cycles. A start with op=LOAD issued mid-run is ignored: Q is not loaded and done pulses only once.
- Assert n_reset low during a ROL with amt=6 while busy: Q=0, cout=0, busy=0, done=0 immediately. After release, a new LOAD is accepted on the first edge.
